load_store_extender: RTL and testbench
======================================

Name: load_store_extender

Overview:
Parametrised successor to the combinational sign/zero extender. It runs the full MIPS sub-word memory access sequence: LB/LBU/LH/LHU/LW loads and SB/SH/SW stores.
- Loads: reads the aligned word, selects the byte or halfword lane, then sign- or zero-extends it.
- Sub-word stores: performs a read-modify-write on the aligned word.
- Misaligned accesses: detected and reported; no memory access is made.
- Placement: sits between the multicycle control unit and the data memory, with a start/done handshake.

Parameters:
DATA_W, 32, data and address width (must be 32; lane logic is fixed to 4 bytes).
MEM_LAT, 1, data memory read latency in cycles (legal 1..4).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request pulse; sampled only in IDLE.
op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
addr  in  DATA_W  byte address.
store_data  in  DATA_W  store source; low 8 bits for SB, low 16 bits for SH.
mem_rdata  in  DATA_W  data memory read data.
mem_addr  out  DATA_W  word-aligned address {addr[31:2],2'b00}.
mem_re  out  1  read enable.
mem_we  out  1  write enable.
mem_wdata  out  DATA_W  write data.
load_result  out  DATA_W  extended load value.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle completion pulse.
misaligned  out  1  qualifies done: access rejected.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, counter=0.
  - All outputs 0, including load_result and misaligned.
  - Overrides any state, so asserting reset mid-operation (including during WR) leaves mem_we=0 from the next cycle.
- IDLE + start=1 latches op, addr and store_data. start while busy=1 is ignored; no queueing.
- Alignment checks:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=00.
  - On violation: next state is DONE with misaligned=1; no mem_re/mem_we; load_result unchanged.
- States:
  - IDLE.
  - RD: MEM_LAT cycles, mem_re=1, mem_addr driven.
  - CAP: 1 cycle, mem_addr held, mem_rdata captured at end of cycle.
  - WR: 1 cycle, mem_we=1, mem_addr and mem_wdata driven.
  - DONE: 1 cycle, done=1, then IDLE.
- Paths (start accepted in cycle T):
  - Loads: IDLE -> RD -> CAP -> DONE. done in cycle T+MEM_LAT+2.
  - SW: IDLE -> WR -> DONE. No read; mem_wdata=store_data; done in T+2.
  - SB/SH: IDLE -> RD -> CAP -> WR -> DONE. done in T+MEM_LAT+3.
  - Misaligned: IDLE -> DONE. done in T+1.
- Lane selection is little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword h = addr[1] occupies bits [16h+15:16h].
- Extension:
  - LB/LH replicate the lane MSB into the upper bits.
  - LBU/LHU zero-fill the upper bits.
  - LW passes the word through.
- load_result:
  - Written at the end of CAP for loads only.
  - Held until the next completed load.
  - Stores and misaligned requests never change it.
- Merge: SB/SH replace only the selected lane of the captured word with store_data[7:0] / store_data[15:0]; other lanes are preserved.
- Outputs outside the states that drive them: mem_addr=0, mem_wdata=0, mem_re=0, mem_we=0.
- misaligned: valid only while done=1; 0 otherwise.
- Back-to-back: a start in the IDLE cycle immediately after DONE is accepted.

Test Plan:
1. Reset for 2 cycles with random inputs -> all outputs 0, busy=0. Then start LW with addr 0x100, mem word 0xDEADBEEF, MEM_LAT=1 -> mem_re high in T+1 only, done in T+3, load_result=0xDEADBEEF.
2. Mem word 0x80FF1234:
   - LB addr 0x103 -> load_result 0xFFFFFF80.
   - LBU addr 0x103 -> 0x00000080.
   - LB addr 0x100 -> 0x00000034.
3. Mem word 0x80017FFF:
   - LH addr 0x102 -> 0xFFFF8001.
   - LHU addr 0x102 -> 0x00008001.
   - LH addr 0x100 -> 0x00007FFF.
   - Repeat the set with MEM_LAT=3 -> done in T+5.
4. Mem word 0x11223344:
   - SB addr 0x201, store_data 0xFFFFFFAB -> one write to mem_addr 0x200 with 0x1122AB44; mem_we high exactly 1 cycle; done in T+4.
   - SH addr 0x202, store_data 0x0000BEEF -> write 0xBEEF3344.
   - SW addr 0x204 -> no mem_re; write in T+1; done in T+2.
5. LW addr 0x102, then SH addr 0x203 -> done in T+1 with misaligned=1; mem_re=mem_we=0 throughout; load_result keeps its previous value.
6. start pulses while busy -> ignored, and the original op completes unchanged. Reset asserted during WR of an SB -> mem_we=0, busy=0 next cycle, then a new LW completes normally.

Source files
------------

// File: rtl/load_store_extender.sv
// load_store_extender: sequences MIPS sub-word loads (LB/LBU/LH/LHU/LW) and
// stores (SB/SH/SW) against a word-wide data memory with fixed read latency.
// Sub-word stores read-modify-write the aligned word; misaligned requests are
// rejected without touching memory.
module load_store_extender #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] load_result,
   output logic              busy,
   output logic              done,
   output logic              misaligned
);

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LBU = 3'b001,
      OP_LH  = 3'b010,
      OP_LHU = 3'b011,
      OP_LW  = 3'b100,
      OP_SB  = 3'b101,
      OP_SH  = 3'b110,
      OP_SW  = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_DONE
   } state_e;

   // RD dwell counter; MEM_LAT is limited to 1..4 so two bits suffice.
   localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   op_e               op_q, op_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] sdata_q, sdata_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [DATA_W-1:0] load_q, load_d;
   logic              misal_q, misal_d;

   logic              misal_req;
   logic              accept;
   logic              is_load;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;
   logic [DATA_W-1:0] ext_val;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] aligned_addr;

   assign accept       = (state_q == S_IDLE) && start;
   assign is_load      = op_q inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
   assign aligned_addr = {addr_q[DATA_W-1:2], 2'b00};
   assign load_result  = load_q;

   // Alignment check on the incoming request (evaluated only when accepted).
   always_comb begin
      misal_req = 1'b0;
      case (op_e'(op))
         OP_LH, OP_LHU, OP_SH: misal_req = addr[0];
         OP_LW, OP_SW:         misal_req = |addr[1:0];
         default:              misal_req = 1'b0;
      endcase
   end

   // Little-endian lane selection and sign/zero extension of the read word.
   always_comb begin
      byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (op_q)
         OP_LB:   ext_val = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
         OP_LBU:  ext_val = {{(DATA_W-8){1'b0}}, byte_lane};
         OP_LH:   ext_val = {{(DATA_W-16){half_lane[15]}}, half_lane};
         OP_LHU:  ext_val = {{(DATA_W-16){1'b0}}, half_lane};
         default: ext_val = mem_rdata;
      endcase
   end

   // Store data merge: replace only the addressed lane of the captured word.
   always_comb begin
      merged = word_q;
      case (op_q)
         OP_SB:   merged[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
         OP_SH:   merged[{addr_q[1], 4'b0000} +: 16] = sdata_q[15:0];
         default: merged = sdata_q;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (misal_req)                 state_d = S_DONE;
               else if (op_e'(op) == OP_SW)   state_d = S_WR;
               else                           state_d = S_RD;
            end
         end
         S_RD:    if (cnt_q == LAT_LAST) state_d = S_CAP;
         S_CAP:   state_d = is_load ? S_DONE : S_WR;
         S_WR:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: memory strobes and handshake driven only by their states.
   always_comb begin
      mem_addr   = '0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      done       = 1'b0;
      misaligned = 1'b0;
      busy       = (state_q != S_IDLE);
      case (state_q)
         S_RD: begin
            mem_re   = 1'b1;
            mem_addr = aligned_addr;
         end
         S_CAP:   mem_addr = aligned_addr;
         S_WR: begin
            mem_we    = 1'b1;
            mem_addr  = aligned_addr;
            mem_wdata = merged;
         end
         S_DONE: begin
            done       = 1'b1;
            misaligned = misal_q;
         end
         default: ;
      endcase
   end

   // Datapath next-state: request latch, latency counter, read capture.
   always_comb begin
      op_d    = op_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      misal_d = misal_q;
      word_d  = word_q;
      load_d  = load_q;
      cnt_d   = '0;
      if (accept) begin
         op_d    = op_e'(op);
         addr_d  = addr;
         sdata_d = store_data;
         misal_d = misal_req;
      end
      if (state_q == S_RD) cnt_d = cnt_q + 2'd1;
      if (state_q == S_CAP) begin
         word_d = mem_rdata;
         if (is_load) load_d = ext_val;
      end
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         op_q    <= OP_LB;
         addr_q  <= '0;
         sdata_q <= '0;
         word_q  <= '0;
         load_q  <= '0;
         misal_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         word_q  <= word_d;
         load_q  <= load_d;
         misal_q <= misal_d;
      end
   end

endmodule

// File: tb/tb_load_store_extender.sv
// Bench for load_store_extender: two instances (MEM_LAT=1 and MEM_LAT=3)
// share stimulus and a word memory model; a scoreboard queue holds expected
// completions which a negedge monitor pops on done.
module tb_load_store_extender;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        accept = 1'b0;
   logic        sel = 1'b0;
   logic        mon_en = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   int unsigned cyc = 0;

   logic [31:0] rd1, ma1, wd1, lr1;
   logic        re1, we1, busy1, done1, mis1;
   logic [31:0] rd3, ma3, wd3, lr3;
   logic        re3, we3, busy3, done3, mis3;

   logic [31:0] o_mem_addr, o_mem_wdata, o_load_result;
   logic        o_mem_re, o_mem_we, o_busy, o_done, o_misaligned;

   always #5 clk = ~clk;

   load_store_extender #(.DATA_W(32), .MEM_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start & ~sel), .op(op), .addr(addr),
      .store_data(store_data), .mem_rdata(rd1), .mem_addr(ma1), .mem_re(re1),
      .mem_we(we1), .mem_wdata(wd1), .load_result(lr1), .busy(busy1),
      .done(done1), .misaligned(mis1)
   );

   load_store_extender #(.DATA_W(32), .MEM_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start & sel), .op(op), .addr(addr),
      .store_data(store_data), .mem_rdata(rd3), .mem_addr(ma3), .mem_re(re3),
      .mem_we(we3), .mem_wdata(wd3), .load_result(lr3), .busy(busy3),
      .done(done3), .misaligned(mis3)
   );

   always_comb begin
      o_mem_addr    = sel ? ma3  : ma1;
      o_mem_wdata   = sel ? wd3  : wd1;
      o_load_result = sel ? lr3  : lr1;
      o_mem_re      = sel ? re3  : re1;
      o_mem_we      = sel ? we3  : we1;
      o_busy        = sel ? busy3 : busy1;
      o_done        = sel ? done3 : done1;
      o_misaligned  = sel ? mis3 : mis1;
   end

   // Memory model: reads return data MEM_LAT cycles after the read strobe;
   // non-read cycles feed junk into the pipe so mistimed captures show up.
   logic [31:0] mem [0:255];
   logic        poke_en = 1'b0;
   logic [7:0]  poke_idx = '0;
   logic [31:0] poke_val = '0;
   logic [31:0] p1 = '0;
   logic [31:0] p3 [0:2];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (poke_en) mem[poke_idx] <= poke_val;
      if (we1) mem[ma1[9:2]] <= wd1;
      if (we3) mem[ma3[9:2]] <= wd3;
      p1    <= re1 ? mem[ma1[9:2]] : (32'hA5A5_5A5A ^ cyc);
      p3[0] <= re3 ? mem[ma3[9:2]] : (32'h5A5A_A5A5 ^ cyc);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   assign rd1 = p1;
   assign rd3 = p3[2];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      string       tag;
      int unsigned t0;
      int unsigned lat;
      logic [31:0] res;
      logic        mis;
      int unsigned n_re;
      int unsigned n_we;
      logic [31:0] raddr;
      logic [31:0] waddr;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];

   // Monitor: tallies memory strobes per transaction, checks on done.
   initial begin
      int unsigned m_re, m_we;
      logic [31:0] m_raddr, m_waddr, m_wdata;
      exp_t e;
      m_re = 0; m_we = 0; m_raddr = '0; m_waddr = '0; m_wdata = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (accept) begin
               m_re = 0; m_we = 0; m_raddr = '0; m_waddr = '0; m_wdata = '0;
            end
            if (o_mem_re) begin m_re++; m_raddr = o_mem_addr; end
            if (o_mem_we) begin m_we++; m_waddr = o_mem_addr; m_wdata = o_mem_wdata; end
            if (o_done) begin
               if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
               else begin
                  e = sb.pop_front();
                  chk({e.tag, "_lat"},   cyc - e.t0, e.lat);
                  chk({e.tag, "_mis"},   {31'b0, o_misaligned}, {31'b0, e.mis});
                  chk({e.tag, "_res"},   o_load_result, e.res);
                  chk({e.tag, "_nre"},   m_re, e.n_re);
                  chk({e.tag, "_nwe"},   m_we, e.n_we);
                  chk({e.tag, "_raddr"}, m_raddr, e.raddr);
                  chk({e.tag, "_waddr"}, m_waddr, e.waddr);
                  chk({e.tag, "_wdata"}, m_wdata, e.wdata);
               end
            end else begin
               chk("misaligned_outside_done", {31'b0, o_misaligned}, 32'd0);
            end
         end
      end
   end

   task automatic poke(input logic [31:0] a, input logic [31:0] v);
      poke_en = 1'b1; poke_idx = a[9:2]; poke_val = v;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   // Issue one request from an IDLE cycle, optionally hammering start while busy.
   task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] res, input logic mis,
                        input int unsigned lat, input int unsigned nre, input int unsigned nwe,
                        input logic [31:0] wdata, input logic stray);
      exp_t e;
      logic seen;
      op = o; addr = a; store_data = sd; start = 1'b1; accept = 1'b1;
      e.tag   = tag;
      e.t0    = cyc;
      e.lat   = lat;
      e.res   = res;
      e.mis   = mis;
      e.n_re  = nre;
      e.n_we  = nwe;
      e.raddr = (nre != 0) ? {a[31:2], 2'b00} : 32'h0;
      e.waddr = (nwe != 0) ? {a[31:2], 2'b00} : 32'h0;
      e.wdata = (nwe != 0) ? wdata : 32'h0;
      sb.push_back(e);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         accept = 1'b0;
         if (o_done) begin start = 1'b0; seen = 1'b1; break; end
         start = stray;
         if (stray) begin op = 3'b111; addr = 32'h100; store_data = 32'h0; end
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         sb.delete();
         start = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned k;
      logic got_wr;
      // Reset for two cycles with random inputs on the request side.
      for (int i = 0; i < 2; i++) begin
         op = 3'($urandom); addr = $urandom; store_data = $urandom; start = 1'($urandom);
         @(posedge clk); #1;
      end
      chk("rst_mem_addr",    o_mem_addr, 32'h0);
      chk("rst_mem_re",      {31'b0, o_mem_re}, 32'h0);
      chk("rst_mem_we",      {31'b0, o_mem_we}, 32'h0);
      chk("rst_mem_wdata",   o_mem_wdata, 32'h0);
      chk("rst_load_result", o_load_result, 32'h0);
      chk("rst_busy",        {31'b0, o_busy}, 32'h0);
      chk("rst_done",        {31'b0, o_done}, 32'h0);
      chk("rst_misaligned",  {31'b0, o_misaligned}, 32'h0);
      start = 1'b0; reset = 1'b0; mon_en = 1'b1;
      @(posedge clk); #1;

      // Loads, MEM_LAT=1: done at T+3, one read cycle.
      poke(32'h100, 32'hDEADBEEF);
      issue("lw100",  3'd4, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0, 32'h0, 1'b0);
      poke(32'h100, 32'h80FF1234);
      issue("lb103",  3'd0, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1, 0, 32'h0, 1'b0);
      issue("lbu103", 3'd1, 32'h103, 32'h0, 32'h00000080, 1'b0, 3, 1, 0, 32'h0, 1'b0);
      issue("lb100",  3'd0, 32'h100, 32'h0, 32'h00000034, 1'b0, 3, 1, 0, 32'h0, 1'b0);
      issue("lb101",  3'd0, 32'h101, 32'h0, 32'h00000012, 1'b0, 3, 1, 0, 32'h0, 1'b0);
      issue("lbu102", 3'd1, 32'h102, 32'h0, 32'h000000FF, 1'b0, 3, 1, 0, 32'h0, 1'b0);
      poke(32'h100, 32'h80017FFF);
      issue("lh102",  3'd2, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 3, 1, 0, 32'h0, 1'b0);
      issue("lhu102", 3'd3, 32'h102, 32'h0, 32'h00008001, 1'b0, 3, 1, 0, 32'h0, 1'b0);
      issue("lh100",  3'd2, 32'h100, 32'h0, 32'h00007FFF, 1'b0, 3, 1, 0, 32'h0, 1'b0);
      issue("lhu100", 3'd3, 32'h100, 32'h0, 32'h00007FFF, 1'b0, 3, 1, 0, 32'h0, 1'b0);

      // Stores: load_result must hold across them.
      poke(32'h200, 32'h11223344);
      issue("sb201",  3'd5, 32'h201, 32'hFFFFFFAB, 32'h00007FFF, 1'b0, 4, 1, 1, 32'h1122AB44, 1'b0);
      poke(32'h200, 32'h11223344);
      issue("sh202",  3'd6, 32'h202, 32'h0000BEEF, 32'h00007FFF, 1'b0, 4, 1, 1, 32'hBEEF3344, 1'b0);
      issue("sw204",  3'd7, 32'h204, 32'hCAFEF00D, 32'h00007FFF, 1'b0, 2, 0, 1, 32'hCAFEF00D, 1'b0);
      issue("lw204",  3'd4, 32'h204, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1, 0, 32'h0, 1'b0);
      issue("sb203",  3'd5, 32'h203, 32'h00000077, 32'hCAFEF00D, 1'b0, 4, 1, 1, 32'h77EF3344, 1'b0);
      issue("sh200",  3'd6, 32'h200, 32'h12345678, 32'hCAFEF00D, 1'b0, 4, 1, 1, 32'h77EF5678, 1'b0);
      issue("sb200",  3'd5, 32'h200, 32'h000000AA, 32'hCAFEF00D, 1'b0, 4, 1, 1, 32'h77EF56AA, 1'b0);
      issue("lw200",  3'd4, 32'h200, 32'h0, 32'h77EF56AA, 1'b0, 3, 1, 0, 32'h0, 1'b0);

      // Misaligned: done at T+1, no memory traffic, load_result held.
      issue("mis_lw102",  3'd4, 32'h102, 32'h0, 32'h77EF56AA, 1'b1, 1, 0, 0, 32'h0, 1'b0);
      issue("mis_sh203",  3'd6, 32'h203, 32'hFFFF, 32'h77EF56AA, 1'b1, 1, 0, 0, 32'h0, 1'b0);
      issue("mis_lh101",  3'd2, 32'h101, 32'h0, 32'h77EF56AA, 1'b1, 1, 0, 0, 32'h0, 1'b0);
      issue("mis_lhu103", 3'd3, 32'h103, 32'h0, 32'h77EF56AA, 1'b1, 1, 0, 0, 32'h0, 1'b0);
      issue("mis_sw206",  3'd7, 32'h206, 32'h0, 32'h77EF56AA, 1'b1, 1, 0, 0, 32'h0, 1'b0);
      issue("mis_lw201",  3'd4, 32'h201, 32'h0, 32'h77EF56AA, 1'b1, 1, 0, 0, 32'h0, 1'b0);
      issue("lw204_chk",  3'd4, 32'h204, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1, 0, 32'h0, 1'b0);

      // Start pulses while busy must be ignored.
      issue("stray_lw100", 3'd4, 32'h100, 32'h0, 32'h80017FFF, 1'b0, 3, 1, 0, 32'h0, 1'b1);
      issue("stray_sb202", 3'd5, 32'h202, 32'h0000003C, 32'h80017FFF, 1'b0, 4, 1, 1, 32'h773C56AA, 1'b1);
      issue("lw100_chk",   3'd4, 32'h100, 32'h0, 32'h80017FFF, 1'b0, 3, 1, 0, 32'h0, 1'b0);

      // Reset asserted during WR of an SB.
      op = 3'd5; addr = 32'h201; store_data = 32'h00000055; start = 1'b1; accept = 1'b1;
      got_wr = 1'b0;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         accept = 1'b0; start = 1'b0;
         if (o_mem_we) begin got_wr = 1'b1; k = i; break; end
      end
      chk("rstwr_reached_wr", {31'b0, got_wr}, 32'd1);
      chk("rstwr_wr_cycle", k, 32'd2);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rstwr_mem_we",      {31'b0, o_mem_we}, 32'd0);
      chk("rstwr_busy",        {31'b0, o_busy}, 32'd0);
      chk("rstwr_done",        {31'b0, o_done}, 32'd0);
      chk("rstwr_load_result", o_load_result, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;
      issue("post_rst_lw200", 3'd4, 32'h200, 32'h0, 32'h773C55AA, 1'b0, 3, 1, 0, 32'h0, 1'b0);

      // MEM_LAT=3 instance: loads done at T+5, SB at T+6.
      sel = 1'b1;
      @(posedge clk); #1;
      issue("l3_lh102",  3'd2, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 5, 3, 0, 32'h0, 1'b0);
      issue("l3_lhu102", 3'd3, 32'h102, 32'h0, 32'h00008001, 1'b0, 5, 3, 0, 32'h0, 1'b0);
      issue("l3_lh100",  3'd2, 32'h100, 32'h0, 32'h00007FFF, 1'b0, 5, 3, 0, 32'h0, 1'b0);
      issue("l3_sb200",  3'd5, 32'h200, 32'h00000011, 32'h00007FFF, 1'b0, 6, 3, 1, 32'h773C5511, 1'b1);
      issue("l3_lw200",  3'd4, 32'h200, 32'h0, 32'h773C5511, 1'b0, 5, 3, 0, 32'h0, 1'b0);
      issue("l3_mis202", 3'd4, 32'h202, 32'h0, 32'h773C5511, 1'b1, 1, 0, 0, 32'h0, 1'b0);
      issue("l3_lw100",  3'd4, 32'h100, 32'h0, 32'h80017FFF, 1'b0, 5, 3, 0, 32'h0, 1'b0);

      @(posedge clk); #1;
      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
